// File: rtl/riscv_fetch_unit_pkg.sv
// Shared constants, state encoding and IF/ID entry type for the fetch stage.
package riscv_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        KILL  = 2'd3
    } fetchState_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcPlus4;
        logic        valid;
    } ifidEntry_t;

    localparam ifidEntry_t BUBBLE_ENTRY = '{
        instr:   NOP_INSTR,
        pc:      32'h0,
        pcPlus4: 32'h0,
        valid:   1'b0
    };

    // Sequential PC; wraps modulo 2^32.
    function automatic logic [31:0] nextPc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    // Force a fetch address onto a word boundary.
    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/riscv_fetch_unit_if.sv
// Instruction-memory req/ack port. The fetch unit is the master; memory
// may acknowledge in the request cycle or any number of cycles later.
interface riscv_fetch_unit_if;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;
    logic [31:0] ImemRData;

    modport master (output ImemReq, output ImemAddr, input ImemAck, input ImemRData);
    modport slave  (input ImemReq, input ImemAddr, output ImemAck, output ImemRData);
endinterface

// File: rtl/riscv_fetch_unit_ifid_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load.
module riscv_ifid_reg
    import riscv_fetch_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       flush,
    input  logic       stall,
    input  ifidEntry_t loadEntry,
    output ifidEntry_t ifidQ
);

    ifidEntry_t ifidReg;

    // Register update: reset/flush write a bubble, stall holds, else load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ifidReg <= BUBBLE_ENTRY;
        end else if (flush) begin
            ifidReg <= BUBBLE_ENTRY;
        end else if (!stall) begin
            ifidReg <= loadEntry;
        end
    end

    assign ifidQ = ifidReg;

endmodule

// File: rtl/riscv_fetch_unit.sv
// RV32I fetch stage: owns PCF, a variable-latency req/ack fetch port, a
// one-word hold buffer for words that arrive during a stall, a redirect
// register for branches resolved while a request is still outstanding,
// and the IF/ID register.
module riscv_fetch_unit
    import riscv_fetch_unit_pkg::*;
(
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       StallF,
    input  logic                       StallD,
    input  logic                       FlushD,
    input  logic                       PCSrcE,
    input  logic [31:0]                PCTargetE,
    riscv_fetch_unit_if.master         imem,
    output logic [31:0]                InstrD,
    output logic [31:0]                PCD,
    output logic [31:0]                PCPlus4D,
    output logic                       ValidD
);

    fetchState_t stateReg, stateNext;
    logic [31:0] pcfReg, pcfNext;
    logic [31:0] redirectReg, redirectNext;
    logic [31:0] holdInstrReg, holdInstrNext;
    logic [31:0] holdPcReg, holdPcNext;

    logic        imemReq;
    logic        deliver;
    logic [31:0] deliverInstr;
    logic [31:0] deliverPc;
    ifidEntry_t  loadEntry;
    ifidEntry_t  ifidQ;

    // State, PC, redirect and hold-buffer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stateReg     <= IDLE;
            pcfReg       <= RESET_PC;
            redirectReg  <= RESET_PC;
            holdInstrReg <= NOP_INSTR;
            holdPcReg    <= RESET_PC;
        end else begin
            stateReg     <= stateNext;
            pcfReg       <= pcfNext;
            redirectReg  <= redirectNext;
            holdInstrReg <= holdInstrNext;
            holdPcReg    <= holdPcNext;
        end
    end

    // Next-state logic: a request, once raised, is held until its ack, so a
    // branch seen mid-request is parked in redirectReg and the late word is
    // thrown away in KILL.
    always_comb begin
        stateNext     = stateReg;
        pcfNext       = pcfReg;
        redirectNext  = redirectReg;
        holdInstrNext = holdInstrReg;
        holdPcNext    = holdPcReg;
        imemReq       = 1'b0;
        deliver       = 1'b0;
        deliverInstr  = holdInstrReg;
        deliverPc     = holdPcReg;

        unique case (stateReg)
            IDLE: begin
                stateNext = FETCH;
            end
            FETCH: begin
                imemReq = 1'b1;
                if (imem.ImemAck) begin
                    if (PCSrcE) begin
                        pcfNext = alignWord(PCTargetE);
                    end else if (!StallF) begin
                        deliver      = 1'b1;
                        deliverInstr = imem.ImemRData;
                        deliverPc    = pcfReg;
                        pcfNext      = nextPc(pcfReg);
                    end else begin
                        holdInstrNext = imem.ImemRData;
                        holdPcNext    = pcfReg;
                        stateNext     = HOLD;
                    end
                end else if (PCSrcE) begin
                    redirectNext = alignWord(PCTargetE);
                    stateNext    = KILL;
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    pcfNext   = alignWord(PCTargetE);
                    stateNext = FETCH;
                end else if (!StallF) begin
                    deliver   = 1'b1;
                    pcfNext   = nextPc(pcfReg);
                    stateNext = FETCH;
                end
            end
            KILL: begin
                imemReq = 1'b1;
                if (imem.ImemAck) begin
                    // A branch arriving with the ack is the newest target.
                    pcfNext   = PCSrcE ? alignWord(PCTargetE) : redirectReg;
                    stateNext = FETCH;
                end else if (PCSrcE) begin
                    redirectNext = alignWord(PCTargetE);
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Value offered to IF/ID: the delivered word, otherwise a bubble.
    always_comb begin
        loadEntry = BUBBLE_ENTRY;
        if (deliver) begin
            loadEntry = '{instr:   deliverInstr,
                          pc:      deliverPc,
                          pcPlus4: nextPc(deliverPc),
                          valid:   1'b1};
        end
    end

    riscv_ifid_reg ifidRegInst (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (FlushD),
        .stall     (StallD),
        .loadEntry (loadEntry),
        .ifidQ     (ifidQ)
    );

    assign imem.ImemReq  = imemReq;
    assign imem.ImemAddr = pcfReg;   // pcfReg is only ever loaded aligned
    assign InstrD        = ifidQ.instr;
    assign PCD           = ifidQ.pc;
    assign PCPlus4D      = ifidQ.pcPlus4;
    assign ValidD        = ifidQ.valid;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Randomized bench for riscv_fetch_unit: a variable-latency memory and a
// random hazard unit drive the DUT; a flag-based model of the fetch stream
// predicts the fetch port and the IF/ID contents every cycle.
module tb_riscv_fetch_unit;
    import riscv_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        StallF = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'h0;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    riscv_fetch_unit_if imemBus();

    riscv_fetch_unit dut (
        .clk       (clk),
        .rstn      (rstn),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .imem      (imemBus),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Memory contents: a fixed scramble of the address, never a NOP.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A00_0001;
    endfunction

    // Model of the fetch stream.
    bit          mStarted;    // the post-reset idle cycle has passed
    bit          mKill;       // outstanding request belongs to a dead path
    bit          mHeld;       // a fetched word is waiting out a stall
    logic [31:0] mPc, mRedirect, mHeldWord, mHeldPc;
    logic [31:0] eInstr, ePc;
    bit          eValid;

    // Memory state.
    bit memBusy;
    int memWait;
    bit ackNow;

    task automatic modelReset();
        mStarted = 1'b0; mKill = 1'b0; mHeld = 1'b0;
        mPc = RESET_PC; mRedirect = 32'h0; mHeldWord = 32'h0; mHeldPc = 32'h0;
        eInstr = NOP_INSTR; ePc = 32'h0; eValid = 1'b0;
        memBusy = 1'b0; memWait = 0;
    endtask

    task automatic modelStep();
        bit          dlv;
        logic [31:0] dWord, dPc;
        dlv = 1'b0; dWord = 32'h0; dPc = 32'h0;
        if (!mStarted) begin
            mStarted = 1'b1;
        end else if (mHeld) begin
            if (PCSrcE) begin
                mHeld = 1'b0; mPc = PCTargetE;
            end else if (!StallF) begin
                dlv = 1'b1; dWord = mHeldWord; dPc = mHeldPc;
                mHeld = 1'b0; mPc = mPc + 32'd4;
            end
        end else if (mKill) begin
            if (ackNow) begin
                mPc = PCSrcE ? PCTargetE : mRedirect;
                mKill = 1'b0;
            end else if (PCSrcE) begin
                mRedirect = PCTargetE;
            end
        end else begin
            if (ackNow) begin
                if (PCSrcE) begin
                    mPc = PCTargetE;
                end else if (!StallF) begin
                    dlv = 1'b1; dWord = memWord(mPc); dPc = mPc;
                    mPc = mPc + 32'd4;
                end else begin
                    mHeld = 1'b1; mHeldWord = memWord(mPc); mHeldPc = mPc;
                end
            end else if (PCSrcE) begin
                mKill = 1'b1; mRedirect = PCTargetE;
            end
        end
        if (FlushD) begin
            eInstr = NOP_INSTR; eValid = 1'b0;
        end else if (!StallD) begin
            eInstr = dlv ? dWord : NOP_INSTR;
            ePc    = dPc;
            eValid = dlv;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkEq({tag, ".ImemReq"},  32'(imemBus.ImemReq), 32'h0);
        checkEq({tag, ".ImemAddr"}, imemBus.ImemAddr, RESET_PC);
        checkEq({tag, ".InstrD"},   InstrD, NOP_INSTR);
        checkEq({tag, ".PCD"},      PCD, 32'h0);
        checkEq({tag, ".PCPlus4D"}, PCPlus4D, 32'h0);
        checkEq({tag, ".ValidD"},   32'(ValidD), 32'h0);
    endtask

    initial begin
        bit hazards, slowMem, didReset;
        imemBus.ImemAck   = 1'b0;
        imemBus.ImemRData = 32'h0;
        modelReset();
        didReset = 1'b0;

        #12;
        checkResetOutputs("reset");
        #15;                    // release between edges
        rstn = 1'b1;

        for (int cyc = 0; cyc < 600; cyc++) begin
            hazards = (cyc >= 100);
            slowMem = (cyc >= 40);

            // Hazard-unit stimulus.
            if (hazards) begin
                StallF = ($urandom % 5) == 0;
                StallD = (($urandom % 8) == 0) ? 1'($urandom % 2) : StallF;
                PCSrcE = ($urandom % 10) == 0;
                FlushD = PCSrcE ? (($urandom % 4) != 0) : (($urandom % 16) == 0);
                if (($urandom % 8) == 0)
                    PCTargetE = 32'hFFFF_FFF8 + 32'(($urandom % 2) * 4);
                else
                    PCTargetE = 32'($urandom_range(0, 1023)) << 2;
            end else begin
                StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
            end

            // Memory: each request gets a random latency, ack may be immediate.
            ackNow = 1'b0;
            if (imemBus.ImemReq) begin
                if (!memBusy) begin
                    memBusy = 1'b1;
                    memWait = slowMem ? $urandom_range(0, 3) : 0;
                end
                if (memWait == 0) begin
                    ackNow  = 1'b1;
                    memBusy = 1'b0;
                end else begin
                    memWait--;
                end
            end
            imemBus.ImemAck   = ackNow;
            imemBus.ImemRData = ackNow ? memWord(imemBus.ImemAddr) : $urandom;

            #1;
            checkEq("ImemReq", 32'(imemBus.ImemReq), 32'(mStarted && !mHeld));
            if (mStarted && !mHeld)
                checkEq("ImemAddr", imemBus.ImemAddr, mPc);
            modelStep();

            @(posedge clk);
            #1;
            checkEq("ValidD", 32'(ValidD), 32'(eValid));
            checkEq("InstrD", InstrD, eInstr);
            if (eValid) begin
                checkEq("PCD", PCD, ePc);
                checkEq("PCPlus4D", PCPlus4D, ePc + 32'd4);
                $display("cycle %0d ID pc=%08h instr=%08h", cyc, PCD, InstrD);
            end

            // Asynchronous reset pulse, preferably while a request is pending.
            if (!didReset && cyc >= 300 && (memBusy || cyc >= 360)) begin
                didReset = 1'b1;
                #3;
                imemBus.ImemAck = 1'b0;
                rstn = 1'b0;
                #1;
                checkResetOutputs("midreset");
                #2;
                rstn = 1'b1;
                modelReset();
                $display("cycle %0d reset pulse", cyc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
